// File: rtl/opc5_memctl.sv
// opc5_memctl: OPC5 CPU to asynchronous SRAM controller with programmable wait states
// Ports: clk, reset (async, active-high); CPU side cpu_req/cpu_rnw/cpu_addr/cpu_wdata in,
//   cpu_rdata/cpu_ack out; SRAM side sram_addr/sram_wdata/sram_data_oe and active-low
//   sram_ce_b/sram_oe_b/sram_we_b out, sram_rdata in; prot_err sticky blocked-write flag.
// Option: define OPC5_MEMCTL_WRPROTECT_EN to suppress writes at word addresses >= PROTECT_BASE.
module opc5_memctl #(
   parameter int unsigned WAIT_STATES  = 2,
   parameter logic [15:0] PROTECT_BASE = 16'hF000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_rnw,
   input  logic [15:0] cpu_addr,
   input  logic [15:0] cpu_wdata,
   output logic [15:0] cpu_rdata,
   output logic        cpu_ack,
   output logic [15:0] sram_addr,
   output logic [15:0] sram_wdata,
   input  logic [15:0] sram_rdata,
   output logic        sram_data_oe,
   output logic        sram_ce_b,
   output logic        sram_oe_b,
   output logic        sram_we_b,
   output logic        prot_err
);
`ifdef OPC5_MEMCTL_WRPROTECT_EN
   localparam bit WRPROT = 1'b1;
`else
   localparam bit WRPROT = 1'b0;
`endif
   typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
   state_t     state;
   logic [3:0] cnt;
   logic       rnw;
   logic       blk;
   logic       hit;
   // a write that must run the full bus timing with the write strobe and pad drive suppressed
   assign hit = WRPROT && !cpu_rnw && cpu_addr >= PROTECT_BASE;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state        <= IDLE;
         cnt          <= 4'd0;
         rnw          <= 1'b1;
         blk          <= 1'b0;
         cpu_rdata    <= 16'h0000;
         cpu_ack      <= 1'b0;
         sram_addr    <= 16'h0000;
         sram_wdata   <= 16'h0000;
         sram_data_oe <= 1'b0;
         sram_ce_b    <= 1'b1;
         sram_oe_b    <= 1'b1;
         sram_we_b    <= 1'b1;
         prot_err     <= 1'b0;
      end else begin
         case (state)
            IDLE: if (cpu_req) begin
               state        <= SETUP;
               rnw          <= cpu_rnw;
               blk          <= hit;
               sram_addr    <= cpu_addr;
               sram_wdata   <= cpu_wdata;
               sram_ce_b    <= 1'b0;
               sram_data_oe <= !cpu_rnw && !hit;
            end
            SETUP: begin
               state     <= STROBE;
               cnt       <= 4'(WAIT_STATES);
               sram_oe_b <= !rnw;
               sram_we_b <= rnw || blk;
            end
            STROBE: if (cnt == 4'd0) begin
               // this edge ends the last strobe cycle: sample read data and raise ack
               state     <= HOLD;
               sram_oe_b <= 1'b1;
               sram_we_b <= 1'b1;
               cpu_ack   <= 1'b1;
               cpu_rdata <= rnw ? sram_rdata : cpu_rdata;
               prot_err  <= prot_err || blk;
            end else
               cnt <= cnt - 4'd1;
            HOLD: begin
               state        <= IDLE;
               cpu_ack      <= 1'b0;
               sram_ce_b    <= 1'b1;
               sram_data_oe <= 1'b0;
            end
         endcase
      end
endmodule

// File: tb/tb_opc5_memctl.sv
// tb_opc5_memctl: directed self-checking bench, instance 0 at WAIT_STATES=2, instance 1 at WAIT_STATES=0
module tb_opc5_memctl;
`ifdef OPC5_MEMCTL_WRPROTECT_EN
   localparam bit PROT = 1'b1;
`else
   localparam bit PROT = 1'b0;
`endif
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req [2];
   logic        rnw [2];
   logic [15:0] addr [2];
   logic [15:0] wdata [2];
   logic [15:0] rdata [2];
   logic        ack [2];
   logic [15:0] sa [2];
   logic [15:0] sw [2];
   logic [15:0] sr [2];
   logic        doe [2];
   logic        ce [2];
   logic        oe [2];
   logic        we [2];
   logic        perr [2];
   logic [15:0] mem [2][65536];
   int          acks [2];
   int          n_chk = 0;
   int          n_fail = 0;
   always #5 clk = ~clk;
   for (genvar g = 0; g < 2; g++) begin : gen_dut
      opc5_memctl #(.WAIT_STATES(g == 0 ? 2 : 0)) dut (
         .clk(clk), .reset(reset), .cpu_req(req[g]), .cpu_rnw(rnw[g]), .cpu_addr(addr[g]),
         .cpu_wdata(wdata[g]), .cpu_rdata(rdata[g]), .cpu_ack(ack[g]), .sram_addr(sa[g]),
         .sram_wdata(sw[g]), .sram_rdata(sr[g]), .sram_data_oe(doe[g]), .sram_ce_b(ce[g]),
         .sram_oe_b(oe[g]), .sram_we_b(we[g]), .prot_err(perr[g]));
      assign sr[g] = mem[g][sa[g]];
   end
   always @(posedge clk)
      for (int g = 0; g < 2; g++)
         if (!ce[g] && !we[g] && doe[g]) mem[g][sa[g]] <= sw[g];
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   always @(negedge clk)
      for (int g = 0; g < 2; g++) begin
         chk("oe_we_exclusive", {31'd0, oe[g] || we[g]}, 32'd1);
         if (ack[g]) acks[g]++;
      end
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic access(input int g, input logic r, input logic [15:0] a, input logic [15:0] d,
                         input logic blocked);
      int ws = g == 0 ? 2 : 0;
      int lat = 0, noe = 0, nwe = 0, ndoe = 0;
      req[g] = 1'b1; rnw[g] = r; addr[g] = a; wdata[g] = d;
      tick;
      req[g] = 1'b0; rnw[g] = ~r; addr[g] = ~a; wdata[g] = ~d;
      chk("setup_addr", sa[g], a);
      chk("setup_strobes", {ce[g], oe[g], we[g]}, 3'b011);
      do begin
         if (!oe[g]) noe++;
         if (!we[g]) nwe++;
         if (doe[g]) ndoe++;
         tick;
         lat++;
      end while (!ack[g] && lat < 20);
      if (doe[g]) ndoe++;
      chk("ack_latency", lat, ws + 2);
      chk("hold_strobes", {ce[g], oe[g], we[g]}, 3'b011);
      chk("hold_addr", sa[g], a);
      chk("oe_cycles", noe, r ? ws + 1 : 0);
      chk("we_cycles", nwe, (r || blocked) ? 0 : ws + 1);
      chk("doe_cycles", ndoe, (r || blocked) ? 0 : ws + 3);
      if (r) chk("read_data", rdata[g], d);
      tick;
      chk("ack_one_cycle", ack[g], 1'b0);
      chk("idle_strobes", {ce[g], oe[g], we[g], doe[g]}, 4'b1110);
      chk("idle_addr_held", sa[g], a);
      if (!r) begin
         chk("write_landed", mem[g][a] === d, !blocked);
         chk("no_stray_write", mem[g][~a] === ~d, 1'b0);
      end
   endtask
   initial begin
      int k, t;
      int at [3];
      for (int g = 0; g < 2; g++) begin
         req[g] = 1'b0; rnw[g] = 1'b1; addr[g] = 16'h0000; wdata[g] = 16'h0000; acks[g] = 0;
      end
      tick;
      tick;
      for (int g = 0; g < 2; g++) begin
         chk("rst_ack", ack[g], 1'b0);
         chk("rst_rdata", rdata[g], 16'h0000);
         chk("rst_addr", sa[g], 16'h0000);
         chk("rst_wdata", sw[g], 16'h0000);
         chk("rst_strobes", {ce[g], oe[g], we[g], doe[g]}, 4'b1110);
         chk("rst_prot", perr[g], 1'b0);
      end
      reset = 1'b0;
      tick;
      access(0, 1'b0, 16'h0123, 16'hBEEF, 1'b0);
      access(0, 1'b1, 16'h0123, 16'hBEEF, 1'b0);
      access(0, 1'b0, 16'h0124, 16'h7777, 1'b0);
      chk("rdata_kept_on_write", rdata[0], 16'hBEEF);
      access(1, 1'b0, 16'h0040, 16'h5A5A, 1'b0);
      access(1, 1'b1, 16'h0040, 16'h5A5A, 1'b0);
      access(1, 1'b0, 16'hF800, 16'h1234, PROT);
      chk("prot_err_set", perr[1], PROT);
      chk("prot_err_other", perr[0], 1'b0);
      for (int i = 0; i < 3; i++) access(0, 1'b0, 16'h0010 + 16'(i), 16'h1111 * 16'(i + 1), 1'b0);
      req[0] = 1'b1; rnw[0] = 1'b1; addr[0] = 16'h0010; k = 0; t = 0;
      while (k < 3 && t < 60) begin
         tick;
         t++;
         if (ack[0]) begin
            at[k] = t;
            chk("b2b_data", rdata[0], 16'h1111 * 16'(k + 1));
            k++;
            addr[0] = 16'h0010 + 16'(k);
            if (k == 3) req[0] = 1'b0;
         end
      end
      req[0] = 1'b0;
      chk("b2b_count", k, 3);
      chk("b2b_first", at[0], 5);
      chk("b2b_gap1", at[1] - at[0], 6);
      chk("b2b_gap2", at[2] - at[1], 6);
      tick;
      tick;
      req[0] = 1'b1; rnw[0] = 1'b0; addr[0] = 16'h0077; wdata[0] = 16'hCAFE;
      tick;
      req[0] = 1'b0;
      tick;
      chk("abort_we_low", we[0], 1'b0);
      k = acks[0];
      #1 reset = 1'b1;
      #1;
      chk("abort_strobes", {ce[0], oe[0], we[0], doe[0]}, 4'b1110);
      chk("abort_ack", ack[0], 1'b0);
      tick;
      tick;
      reset = 1'b0;
      tick;
      tick;
      chk("abort_no_ack", acks[0], k);
      chk("abort_idle", {ce[0], oe[0], we[0], doe[0]}, 4'b1110);
      chk("prot_err_cleared", perr[1], 1'b0);
      chk("rdata_reset", rdata[0], 16'h0000);
      access(0, 1'b1, 16'h0123, 16'hBEEF, 1'b0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
